// File: rtl/id_ex_register.sv
// id_ex_register: Decode-to-Execute pipeline register with stall, flush-to-bubble and a saturating bubble counter.
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flushE,
  input  logic              stallE,
  input  logic              validD,
  input  logic              regWriteD,
  input  logic              memToRegD,
  input  logic              memWriteD,
  input  logic              ALUSrcD,
  input  logic              regDstD,
  input  logic [2:0]        ALUControlD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [REG_W-1:0]  RsD,
  input  logic [REG_W-1:0]  RtD,
  input  logic [REG_W-1:0]  RdD,
  input  logic [DATA_W-1:0] signImmD,
  output logic              regWriteE,
  output logic              memToRegE,
  output logic              memWriteE,
  output logic              ALUSrcE,
  output logic              regDstE,
  output logic [2:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] signImmE,
  output logic [REG_W-1:0]  RsE,
  output logic [REG_W-1:0]  RtE,
  output logic [REG_W-1:0]  RdE,
  output logic              validE,
  output logic [CNT_W-1:0]  bubbleCount
);
  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      regWriteE   <= 1'b0;
      memToRegE   <= 1'b0;
      memWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      regDstE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      signImmE    <= '0;
      RsE         <= '0;
      RtE         <= '0;
      RdE         <= '0;
      validE      <= 1'b0;
    end else if (!stallE) begin
      regWriteE   <= regWriteD;
      memToRegE   <= memToRegD;
      memWriteE   <= memWriteD;
      ALUSrcE     <= ALUSrcD;
      regDstE     <= regDstD;
      ALUControlE <= ALUControlD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      signImmE    <= signImmD;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= RdD;
      validE      <= validD;
    end
    if (reset) bubbleCount <= '0;
    else if (flushE && !(&bubbleCount)) bubbleCount <= bubbleCount + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: table-driven scoreboard bench for id_ex_register, plus a saturation run on a 4-bit counter instance.
module tb_id_ex_register;
  typedef struct packed {
    logic        regWrite;
    logic        memToReg;
    logic        memWrite;
    logic        ALUSrc;
    logic        regDst;
    logic [2:0]  ALUControl;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [31:0] signImm;
    logic        valid;
  } entry_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       flush;
    logic       stall;
    entry_t     d;
    entry_t     expE;
    logic [15:0] expCnt;
    logic [3:0]  expCnt4;
  } vec_t;

  typedef struct {
    string       name;
    entry_t      expE;
    logic [15:0] expCnt;
    logic [3:0]  expCnt4;
  } sb_t;

  logic clk = 1'b0;
  logic reset, flushE, stallE;
  entry_t dIn, eOut, eOut4;
  logic [15:0] bubbleCount;
  logic [3:0] bubbleCount4;
  vec_t vecs[$];
  sb_t sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .reset(reset), .flushE(flushE), .stallE(stallE), .validD(dIn.valid),
    .regWriteD(dIn.regWrite), .memToRegD(dIn.memToReg), .memWriteD(dIn.memWrite),
    .ALUSrcD(dIn.ALUSrc), .regDstD(dIn.regDst), .ALUControlD(dIn.ALUControl),
    .RD1D(dIn.RD1), .RD2D(dIn.RD2), .RsD(dIn.Rs), .RtD(dIn.Rt), .RdD(dIn.Rd), .signImmD(dIn.signImm),
    .regWriteE(eOut.regWrite), .memToRegE(eOut.memToReg), .memWriteE(eOut.memWrite),
    .ALUSrcE(eOut.ALUSrc), .regDstE(eOut.regDst), .ALUControlE(eOut.ALUControl),
    .RD1E(eOut.RD1), .RD2E(eOut.RD2), .signImmE(eOut.signImm),
    .RsE(eOut.Rs), .RtE(eOut.Rt), .RdE(eOut.Rd), .validE(eOut.valid), .bubbleCount(bubbleCount)
  );

  id_ex_register #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flushE(flushE), .stallE(stallE), .validD(dIn.valid),
    .regWriteD(dIn.regWrite), .memToRegD(dIn.memToReg), .memWriteD(dIn.memWrite),
    .ALUSrcD(dIn.ALUSrc), .regDstD(dIn.regDst), .ALUControlD(dIn.ALUControl),
    .RD1D(dIn.RD1), .RD2D(dIn.RD2), .RsD(dIn.Rs), .RtD(dIn.Rt), .RdD(dIn.Rd), .signImmD(dIn.signImm),
    .regWriteE(eOut4.regWrite), .memToRegE(eOut4.memToReg), .memWriteE(eOut4.memWrite),
    .ALUSrcE(eOut4.ALUSrc), .regDstE(eOut4.regDst), .ALUControlE(eOut4.ALUControl),
    .RD1E(eOut4.RD1), .RD2E(eOut4.RD2), .signImmE(eOut4.signImm),
    .RsE(eOut4.Rs), .RtE(eOut4.Rt), .RdE(eOut4.Rd), .validE(eOut4.valid), .bubbleCount(bubbleCount4)
  );

  function automatic entry_t mk(input logic rw, mtr, mw, as, rdst, input logic [2:0] alu,
                                input logic [31:0] rd1, rd2, input logic [4:0] rs, rt, rd,
                                input logic [31:0] imm, input logic v);
    entry_t e;
    e.regWrite = rw; e.memToReg = mtr; e.memWrite = mw; e.ALUSrc = as; e.regDst = rdst;
    e.ALUControl = alu; e.RD1 = rd1; e.RD2 = rd2; e.Rs = rs; e.Rt = rt; e.Rd = rd;
    e.signImm = imm; e.valid = v;
    return e;
  endfunction

  function automatic void addVec(input string n, input logic r, f, s, input entry_t d, e,
                                 input logic [15:0] c);
    vec_t v;
    v.name = n; v.rst = r; v.flush = f; v.stall = s; v.d = d; v.expE = e;
    v.expCnt = c; v.expCnt4 = c[3:0];
    vecs.push_back(v);
  endfunction

  task automatic step(input string n, input logic r, f, s, input entry_t d, e,
                      input logic [15:0] c, input logic [3:0] c4);
    sb_t x;
    sb_t got;
    reset = r; flushE = f; stallE = s; dIn = d;
    x.name = n; x.expE = e; x.expCnt = c; x.expCnt4 = c4;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    tests++;
    if (eOut !== got.expE) begin
      fails++;
      $display("FAIL %s entry: got %h want %h", got.name, eOut, got.expE);
    end
    tests++;
    if (bubbleCount !== got.expCnt) begin
      fails++;
      $display("FAIL %s bubbleCount: got %0d want %0d", got.name, bubbleCount, got.expCnt);
    end
    tests++;
    if (bubbleCount4 !== got.expCnt4) begin
      fails++;
      $display("FAIL %s bubbleCount4: got %0d want %0d", got.name, bubbleCount4, got.expCnt4);
    end
  endtask

  initial begin
    entry_t z, addE, lwE, x1, x2, swE, nv, x3;
    z    = '0;
    addE = mk(1, 0, 0, 0, 1, 3'b010, 32'h5, 32'h7, 5'd1, 5'd2, 5'd3, 32'h0, 1);
    lwE  = mk(0, 1, 0, 1, 0, 3'b010, 32'h100, 32'h0, 5'd4, 5'd5, 5'd0, 32'hFFFFFFFC, 1);
    x1   = mk(1, 0, 0, 0, 1, 3'b110, 32'hAA, 32'hBB, 5'd6, 5'd7, 5'd8, 32'h0, 1);
    x2   = mk(0, 0, 0, 0, 0, 3'b111, 32'h11, 32'h22, 5'd9, 5'd10, 5'd11, 32'h33, 1);
    swE  = mk(0, 0, 1, 1, 0, 3'b010, 32'h44, 32'h55, 5'd12, 5'd13, 5'd0, 32'h8, 1);
    nv   = mk(1, 0, 0, 0, 1, 3'b001, 32'h9, 32'h9, 5'd1, 5'd1, 5'd1, 32'h0, 0);
    x3   = mk(1, 1, 1, 1, 1, 3'b101, 32'hFFFFFFFF, 32'h80000000, 5'd31, 5'd31, 5'd31, 32'h7FFFFFFF, 1);
    addVec("reset0",        1, 0, 0, addE, z,    0);
    addVec("reset1",        1, 1, 1, addE, z,    0);
    addVec("add",           0, 0, 0, addE, addE, 0);
    addVec("lw",            0, 0, 0, lwE,  lwE,  0);
    addVec("stall1",        0, 0, 1, x1,   lwE,  0);
    addVec("stall2",        0, 0, 1, x2,   lwE,  0);
    addVec("stall3",        0, 0, 1, x1,   lwE,  0);
    addVec("unstall",       0, 0, 0, x2,   x2,   0);
    addVec("flushStall",    0, 1, 1, swE,  z,    1);
    addVec("flush",         0, 1, 0, swE,  z,    2);
    addVec("noValid",       0, 0, 0, nv,   nv,   2);
    addVec("aluPass",       0, 0, 0, x3,   x3,   2);
    addVec("flush3",        0, 1, 0, x3,   z,    3);
    addVec("flush4",        0, 1, 0, x3,   z,    4);
    addVec("flush5",        0, 1, 1, x3,   z,    5);
    addVec("stallBubble",   0, 0, 1, addE, z,    5);
    addVec("loadSw",        0, 0, 0, swE,  swE,  5);
    addVec("holdSw",        0, 0, 1, addE, swE,  5);
    addVec("resetMidStall", 1, 0, 1, addE, z,    0);
    addVec("stallAfterRst", 0, 0, 1, addE, z,    0);
    addVec("loadAfterRst",  0, 0, 0, addE, addE, 0);
    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].d, vecs[i].expE,
           vecs[i].expCnt, vecs[i].expCnt4);
    for (int i = 1; i <= 18; i++)
      step($sformatf("sat%0d", i), 0, 1, 0, x3, z, 16'(i), (i > 15) ? 4'd15 : 4'(i));
    step("postSatLoad", 0, 0, 0, addE, addE, 16'd18, 4'd15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameters: DATA_W, 32, datapath operand width; REG_W, 5, register specifier width; CNT_W, 16, bubble counter width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flushE  input  1  replace the next Execute-stage entry with a bubble.
REQ-006 stallE  input  1  hold the current Execute-stage entry.
REQ-007 validD  input  1  decode entry holds a real instruction.
REQ-008 regWriteD, memToRegD, memWriteD, ALUSrcD, regDstD  input  1 each  decode control bits.
REQ-009 ALUControlD  input  3  decode ALU operation.
REQ-010 RD1D, RD2D  input  DATA_W each  register file read data.
REQ-011 RsD, RtD, RdD  input  REG_W each  register specifiers.
REQ-012 signImmD  input  DATA_W  sign-extended immediate.
REQ-013 regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE  output  1 each  registered control bits.
REQ-014 ALUControlE  output  3  registered ALU operation.
REQ-015 RD1E, RD2E, signImmE  output  DATA_W each  registered operands.
REQ-016 RsE, RtE, RdE  output  REG_W each  registered specifiers.
REQ-017 validE  output  1  Execute entry holds a real instruction.
REQ-018 bubbleCount  output  CNT_W  count of flush bubbles inserted.

Function
REQ-019 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-020 Per clock edge, exactly one action SHALL apply, in priority order: reset, flush, stall, load.
REQ-021 Load (flushE=0, stallE=0): every E output SHALL take its D input; latency one cycle.
REQ-022 Stall (flushE=0, stallE=1): every E output SHALL hold its value.
REQ-023 Flush (flushE=1): all control outputs, validE, operands and specifiers SHALL be 0, regardless of stallE.
REQ-024 A bubble SHALL therefore present regWriteE=0 and memWriteE=0, so it never changes architectural state.
REQ-025 bubbleCount SHALL increment by 1 on every non-reset edge with flushE=1, including when stallE=1.
REQ-026 bubbleCount SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 A load with validD=0 SHALL pass all D fields through unchanged with validE=0, and SHALL NOT increment bubbleCount.
REQ-028 ALUControlD values SHALL pass unmodified; the block SHALL NOT decode them.
REQ-029 stallE held across N edges SHALL keep the entry stable for N cycles and then load on the first edge with stallE=0.

Reset
REQ-030 On any edge with reset=1, every output SHALL be 0, including bubbleCount, and flushE and stallE SHALL be ignored.
REQ-031 Reset asserted mid-stall SHALL discard the held entry; the first edge after reset deasserts SHALL follow REQ-020.

Verification
REQ-032 Reset for 2 cycles, then an add entry (regWriteD=1, ALUControlD=010, regDstD=1, RD1D=0x5, RD2D=0x7, RdD=3, validD=1) -> the next cycle shows identical E values, validE=1.
REQ-033 Load lw (memToRegD=1, ALUSrcD=1, signImmD=0xFFFFFFFC), then stallE=1 for 3 cycles while D inputs change -> E stays the lw entry for 3 cycles, then takes the new D on the first unstalled edge.
REQ-034 flushE=1 and stallE=1 together with a sw entry (memWriteD=1) on D -> all E outputs are 0 and bubbleCount increments by 1.
REQ-035 bubbleCount preset near saturation (CNT_W=4, 16 flush cycles) -> the count reaches 15 and remains 15.
REQ-036 reset=1 during a stall with bubbleCount=5 -> all outputs and bubbleCount are 0 on the next cycle; the following load behaves per REQ-021.
REQ-037 Load with validD=0 and regWriteD=1 -> regWriteE=1, validE=0, bubbleCount unchanged.
